hs_word_tx: RTL and testbench

Parametrised successor to the single-bit layer-1 sender. Accepts WIDTH-bit words from the upstream cracker logic into a DEPTH-entry FIFO and transmits each word, in order, over the codebase's rq/ak pulse handshake. Dout holds each word stable for its whole transfer. The block sits between the password-candidate generator and the downstream link layer.

---
 rtl/hs_word_tx_if.sv | 25 ++
 rtl/hs_word_tx.sv | 165 ++++++++++++++++
 tb/tb_hs_word_tx.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_word_tx_if.sv
// Bundles the word-write side and the rq/ak link side of hs_word_tx.
// err only exists when HS_TIMEOUT_EN is defined.
interface hs_word_tx_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             En;
  logic [WIDTH-1:0] Din;
  logic             Rd;
  logic [CW-1:0]    cnt;
  logic             rq;
  logic             ak;
  logic [WIDTH-1:0] Dout;
`ifdef HS_TIMEOUT_EN
  logic             err;

  modport master (input En, Din, ak, output Rd, cnt, rq, Dout, err);
  modport slave  (output En, Din, ak, input Rd, cnt, rq, Dout, err);
`else
  modport master (input En, Din, ak, output Rd, cnt, rq, Dout);
  modport slave  (output En, Din, ak, input Rd, cnt, rq, Dout);
`endif
endinterface

// File: rtl/hs_word_tx.sv
// WIDTH-bit word FIFO feeding an rq/ak pulse-handshake sender; Dout holds each word for its transfer.
// Define HS_TIMEOUT_EN to add an ak wait limit (TIMEOUT cycles) with a sticky err flag.
module hs_word_tx #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  hs_word_tx_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT_HI, WAIT_LO, DONE} state_t;

  state_t           state;
  state_t           stateNext;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dout;
  logic             rq;
  logic             full;
  logic             wrEn;
  logic             popEn;
  logic             rqSet;
  logic             rqClr;

  // Ready comes straight from the registered count, so a pop frees space one cycle later.
  assign full  = (count == CW'(DEPTH));
  assign wrEn  = bus.En && !full;
  assign popEn = (state == LOAD);

  assign bus.Rd   = !full;
  assign bus.cnt  = count;
  assign bus.rq   = rq;
  assign bus.Dout = dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn)
        wrPtr <= wrPtr + 1'b1;
      if (popEn)
        rdPtr <= rdPtr + 1'b1;
      case ({wrEn, popEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn)
      mem[wrPtr] <= bus.Din;
  end

`ifdef HS_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [TW-1:0] tmr;
  logic          tmrExpired;
  logic          timeoutHit;
  logic          err;

  // The wait counter restarts on every state change, so it is zero on entry to either wait state.
  assign tmrExpired = (tmr == TW'(TIMEOUT - 1));
  assign bus.err    = err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmr <= '0;
    else if (stateNext != state)
      tmr <= '0;
    else if (state == WAIT_HI || state == WAIT_LO)
      tmr <= tmr + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if (timeoutHit)
      err <= 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    rqSet     = 1'b0;
    rqClr     = 1'b0;
`ifdef HS_TIMEOUT_EN
    timeoutHit = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (count != '0)
          stateNext = LOAD;
      end
      LOAD: begin
        stateNext = REQ;
      end
      REQ: begin
        rqSet     = 1'b1;
        stateNext = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.ak)
          stateNext = WAIT_LO;
`ifdef HS_TIMEOUT_EN
        else if (tmrExpired) begin
          stateNext  = IDLE;
          rqClr      = 1'b1;
          timeoutHit = 1'b1;
        end
`endif
      end
      WAIT_LO: begin
        if (!bus.ak)
          stateNext = DONE;
`ifdef HS_TIMEOUT_EN
        else if (tmrExpired) begin
          stateNext  = IDLE;
          rqClr      = 1'b1;
          timeoutHit = 1'b1;
        end
`endif
      end
      DONE: begin
        rqClr     = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Dout only moves when a word is popped, so it keeps the last word between transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      rq   <= 1'b0;
    end else begin
      if (popEn)
        dout <= mem[rdPtr];
      if (rqSet)
        rq <= 1'b1;
      else if (rqClr)
        rq <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hs_word_tx.sv
// Self-checking bench for hs_word_tx: directed steps plus randomized bursts against a queue model.
// The HS_TIMEOUT_EN section runs only when that macro is defined for the build.
module tb_hs_word_tx;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  logic [WIDTH-1:0] expQ[$];

  hs_word_tx_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();

  hs_word_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [WIDTH-1:0] din, input logic akv);
    bus.En  = en;
    bus.Din = din;
    bus.ak  = akv;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rq"}, bus.rq, 1'b0);
    checkOutput({tag, "_dout"}, bus.Dout, '0);
    checkOutput({tag, "_rd"}, bus.Rd, 1'b1);
    checkOutput({tag, "_cnt"}, bus.cnt, '0);
`ifdef HS_TIMEOUT_EN
    checkOutput({tag, "_err"}, bus.err, 1'b0);
`endif
  endtask

  task automatic waitRq(input logic level, input int limit);
    int n = 0;
    while (bus.rq !== level && n < limit) begin
      tick();
      n++;
    end
    checkOutput("rq_wait", bus.rq, level);
  endtask

  // One full handshake: ak rises after 'delay' cycles, stays high 'len' cycles; rq must fall two edges after ak drops.
  task automatic serviceWord(input logic [WIDTH-1:0] exp, input int delay, input int len);
    waitRq(1'b1, 30);
    checkOutput("dout_at_rq", bus.Dout, exp);
    repeat (delay) begin
      tick();
      checkOutput("rq_hold", bus.rq, 1'b1);
      checkOutput("dout_hold", bus.Dout, exp);
    end
    applyStimulus(1'b0, '0, 1'b1);
    repeat (len) begin
      tick();
      checkOutput("rq_ak_hi", bus.rq, 1'b1);
    end
    applyStimulus(1'b0, '0, 1'b0);
    tick();
    checkOutput("rq_wait_lo", bus.rq, 1'b1);
    tick();
    checkOutput("rq_fall", bus.rq, 1'b0);
    checkOutput("dout_after", bus.Dout, exp);
  endtask

  task automatic drainAll();
    logic [WIDTH-1:0] w;
    while (expQ.size() > 0) begin
      w = expQ.pop_front();
      serviceWord(w, $urandom_range(0, 3), $urandom_range(1, 3));
      if (expQ.size() > 0) begin
        tick();
        checkOutput("gap_idle_rq", bus.rq, 1'b0);
        checkOutput("gap_idle_dout", bus.Dout, w);
        tick();
        checkOutput("gap_load_dout", bus.Dout, expQ[0]);
        checkOutput("gap_load_rq", bus.rq, 1'b0);
        tick();
        checkOutput("gap_req_rq", bus.rq, 1'b1);
      end
    end
    repeat (3) tick();
    checkOutput("drain_cnt", bus.cnt, '0);
    checkOutput("drain_rq", bus.rq, 1'b0);
    checkOutput("drain_rd", bus.Rd, 1'b1);
  endtask

  // Consecutive writes from an idle, empty block: the first word is popped two edges in,
  // so DEPTH+1 words are accepted and the rest are refused.
  task automatic burst(input int len, input logic randomData);
    logic [WIDTH-1:0] d;
    int occ;
    for (int i = 0; i < len; i++) begin
      d = randomData ? WIDTH'($urandom) : WIDTH'(i + 1);
      applyStimulus(1'b1, d, 1'b0);
      tick();
      if (i < DEPTH + 1)
        expQ.push_back(d);
      occ = (i < 2) ? i + 1 : ((i < DEPTH) ? i : DEPTH);
      checkOutput("burst_cnt", bus.cnt, occ);
      checkOutput("burst_rd", bus.Rd, occ != DEPTH);
    end
    applyStimulus(1'b0, '0, 1'b0);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #3;
    checkResetValues("rst");
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int rqSeen;
    applyStimulus(1'b0, '0, 1'b0);
    rst = 1'b1;
    expQ.delete();

    pulseReset();

    // Single word with exact latency checks.
    applyStimulus(1'b1, 8'hA5, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("single_cnt_n", bus.cnt, 1);
    checkOutput("single_rq_n", bus.rq, 1'b0);
    tick();
    checkOutput("single_dout_n1", bus.Dout, 8'h00);
    checkOutput("single_cnt_n1", bus.cnt, 1);
    tick();
    checkOutput("single_dout_n2", bus.Dout, 8'hA5);
    checkOutput("single_cnt_n2", bus.cnt, 0);
    checkOutput("single_rq_n2", bus.rq, 1'b0);
    tick();
    checkOutput("single_rq_n3", bus.rq, 1'b1);
    serviceWord(8'hA5, 2, 2);
    repeat (3) tick();
    checkOutput("single_cnt_end", bus.cnt, 0);
    checkOutput("single_dout_hold", bus.Dout, 8'hA5);

    // ak while idle must not start anything.
    applyStimulus(1'b0, '0, 1'b1);
    repeat (4) begin
      tick();
      checkOutput("idle_ak_rq", bus.rq, 1'b0);
    end
    applyStimulus(1'b0, '0, 1'b0);
    tick();
    checkOutput("idle_ak_cnt", bus.cnt, 0);
    checkOutput("idle_ak_dout", bus.Dout, 8'hA5);

    // Fill and overflow: 01..06, 06 refused.
    burst(6, 1'b0);
    checkOutput("fill_qsize", expQ.size(), 5);
    drainAll();

    // Write landing in the LOAD cycle with two words queued.
    burst(3, 1'b0);
    serviceWord(expQ.pop_front(), 1, 1);
    tick();
    checkOutput("simul_cnt_pre", bus.cnt, 2);
    applyStimulus(1'b1, 8'h77, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("simul_cnt_post", bus.cnt, 2);
    checkOutput("simul_dout", bus.Dout, 8'h02);
    expQ.push_back(8'h77);
    drainAll();

    // Reset while in WAIT_LO with three words queued.
    burst(4, 1'b1);
    waitRq(1'b1, 30);
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    tick();
    checkOutput("midrst_rq_pre", bus.rq, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkResetValues("midrst");
    applyStimulus(1'b0, '0, 1'b0);
    expQ.delete();
    tick();
    tick();
    rst = 1'b0;
    rqSeen = 0;
    repeat (15) begin
      tick();
      if (bus.rq === 1'b1)
        rqSeen++;
    end
    checkOutput("midrst_no_rq", rqSeen, 0);
    checkOutput("midrst_cnt", bus.cnt, 0);

    // Randomized bursts with random ak timing.
    repeat (6) begin
      burst($urandom_range(1, DEPTH + 3), 1'b1);
      drainAll();
    end

`ifdef HS_TIMEOUT_EN
    // ak never comes: word dropped after TO cycles in WAIT_HI, next word still goes out.
    burst(2, 1'b1);
    waitRq(1'b1, 30);
    rqSeen = 0;
    while (bus.rq === 1'b1 && rqSeen < 3 * TO) begin
      tick();
      rqSeen++;
    end
    checkOutput("timeout_edges", rqSeen, TO);
    checkOutput("timeout_err", bus.err, 1'b1);
    void'(expQ.pop_front());
    drainAll();
    checkOutput("timeout_err_sticky", bus.err, 1'b1);
    pulseReset();
    checkOutput("timeout_err_cleared", bus.err, 1'b0);
`else
    // Without the timeout, WAIT_HI holds indefinitely.
    burst(1, 1'b1);
    waitRq(1'b1, 30);
    repeat (40) tick();
    checkOutput("nowait_limit_rq", bus.rq, 1'b1);
    drainAll();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
